// File: rtl/counter_mod_updn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_mod_updn : modulo-MOD up/down counter, wrap or saturate, cascade |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module counter_mod_updn #(
  parameter int MOD      = 7,
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // One extra bit so MOD = 2^WIDTH is representable and every load is legal.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  generate
    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_params
      $error("counter_mod_updn: MOD must satisfy 2 <= MOD <= 2**WIDTH");
    end
  endgenerate

  logic at_max;
  logic at_min;
  logic load_ok;

  assign at_max  = (q == MAX_VAL);
  assign at_min  = (q == '0);
  assign load_ok = ({1'b0, load_val} < MOD_EXT);
  assign tc      = en & ((up & at_max) | (~up & at_min));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (clr) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      q        <= load_ok ? load_val : MAX_VAL;
      wrap     <= 1'b0;
      load_err <= ~load_ok;
    end else if (en) begin
      load_err <= 1'b0;
      if (up) begin
        if (!at_max) begin
          q    <= q + ONE;
          wrap <= 1'b0;
        end else if (SATURATE) begin
          wrap <= 1'b0;
        end else begin
          q    <= '0;
          wrap <= 1'b1;
        end
      end else begin
        if (!at_min) begin
          q    <= q - ONE;
          wrap <= 1'b0;
        end else if (SATURATE) begin
          wrap <= 1'b0;
        end else begin
          q    <= MAX_VAL;
          wrap <= 1'b1;
        end
      end
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_updn.sv
`default_nettype none
// Scoreboard bench: three standalone counters (modulus 7 wrap, modulus 10 saturate,
// modulus 8 = 2^WIDTH) plus a two-digit modulus-10 cascade, checked against a value model.
module tb_counter_mod_updn;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] clr = '0, load = '0, en = '0, up = '0;
  logic [2:0] lv0 = '0, lv2 = '0;
  logic [3:0] lv1 = '0;
  logic [2:0] q0, q2;
  logic [3:0] q1;
  logic [2:0] tc, wr, le;
  logic cas_en = 1'b0, cas_up = 1'b0;
  logic [3:0] c0_q, c1_q;
  logic c0_tc, c1_tc, c0_wr, c1_wr, c0_le, c1_le;

  counter_mod_updn #(.MOD(7), .WIDTH(3), .SATURATE(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .load(load[0]), .load_val(lv0),
    .en(en[0]), .up(up[0]), .q(q0), .tc(tc[0]), .wrap(wr[0]), .load_err(le[0]));
  counter_mod_updn #(.MOD(10), .WIDTH(4), .SATURATE(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .load(load[1]), .load_val(lv1),
    .en(en[1]), .up(up[1]), .q(q1), .tc(tc[1]), .wrap(wr[1]), .load_err(le[1]));
  counter_mod_updn #(.MOD(8), .WIDTH(3), .SATURATE(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .load(load[2]), .load_val(lv2),
    .en(en[2]), .up(up[2]), .q(q2), .tc(tc[2]), .wrap(wr[2]), .load_err(le[2]));
  counter_mod_updn #(.MOD(10), .WIDTH(4), .SATURATE(1'b0)) u_c0 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(cas_en), .up(cas_up), .q(c0_q), .tc(c0_tc), .wrap(c0_wr), .load_err(c0_le));
  counter_mod_updn #(.MOD(10), .WIDTH(4), .SATURATE(1'b0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(c0_tc), .up(cas_up), .q(c1_q), .tc(c1_tc), .wrap(c1_wr), .load_err(c1_le));

  typedef struct packed {
    logic [2:0][3:0] q;
    logic [2:0]      wr;
    logic [2:0]      le;
    logic [2:0]      tc;
    logic [6:0]      casc;
    logic            ctc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   mq[3];
  int   cv = 0;
  int   mods[3] = '{7, 10, 8};
  bit   sats[3] = '{1'b0, 1'b1, 1'b0};

  function automatic logic [3:0] dq(input int i);
    return (i == 0) ? {1'b0, q0} : (i == 1) ? q1 : {1'b0, q2};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Value-level model of one counter for one edge.
  task automatic model_step(input int i, input bit c, l, input int v, input bit e, u,
                            output bit w, output bit lerr);
    w = 1'b0;
    lerr = 1'b0;
    if (c) mq[i] = 0;
    else if (l) begin
      if (v < mods[i]) mq[i] = v;
      else begin
        mq[i] = mods[i] - 1;
        lerr = 1'b1;
      end
    end else if (e) begin
      if (u) begin
        if (mq[i] + 1 < mods[i]) mq[i] = mq[i] + 1;
        else if (!sats[i]) begin
          mq[i] = 0;
          w = 1'b1;
        end
      end else begin
        if (mq[i] > 0) mq[i] = mq[i] - 1;
        else if (!sats[i]) begin
          mq[i] = mods[i] - 1;
          w = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input logic [2:0] c, l, e, u, input int v0, v1, v2,
                       input logic cen, cup);
    exp_t x;
    int   vv[3];
    bit   w, lerr;
    @(negedge clk);
    clr = c; load = l; en = e; up = u;
    lv0 = 3'(v0); lv1 = 4'(v1); lv2 = 3'(v2);
    cas_en = cen; cas_up = cup;
    vv[0] = v0 & 7; vv[1] = v1 & 15; vv[2] = v2 & 7;
    x = '0;
    for (int i = 0; i < 3; i++) begin
      x.tc[i] = e[i] && (u[i] ? (mq[i] == mods[i] - 1) : (mq[i] == 0));
      model_step(i, c[i], l[i], vv[i], e[i], u[i], w, lerr);
      x.q[i]  = 4'(mq[i]);
      x.wr[i] = w;
      x.le[i] = lerr;
    end
    x.ctc = cen && (cup ? (cv == 99) : (cv == 0));
    if (cen) cv = cup ? (cv + 1) % 100 : (cv + 99) % 100;
    x.casc = 7'(cv);
    sb.push_back(x);
  endtask

  task automatic rnd_cycle();
    logic [2:0] c, l, e, u;
    for (int i = 0; i < 3; i++) begin
      c[i] = ($urandom_range(15) == 0);
      l[i] = ($urandom_range(7) == 0);
      e[i] = ($urandom_range(3) != 0);
      u[i] = 1'($urandom_range(1));
    end
    cycle(c, l, e, u, $urandom_range(7), $urandom_range(15), $urandom_range(7),
          1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic drain();
    @(negedge clk);
    clr = '0; load = '0; en = '0; up = '0; cas_en = 1'b0;
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Monitor: tc is sampled before the edge, registered outputs just after it.
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        for (int i = 0; i < 3; i++) check($sformatf("tc[%0d]", i), tc[i], x.tc[i]);
        check("cascade_tc", c1_tc, x.ctc);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
          check($sformatf("q[%0d]", i), dq(i), x.q[i]);
          check($sformatf("wrap[%0d]", i), wr[i], x.wr[i]);
          check($sformatf("load_err[%0d]", i), le[i], x.le[i]);
        end
        check("cascade_ones", c0_q, x.casc % 10);
        check("cascade_tens", c1_q, x.casc / 10);
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 3; i++) mq[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_q[%0d]", i), dq(i), 0);
      check($sformatf("reset_wrap[%0d]", i), wr[i], 0);
      check($sformatf("reset_load_err[%0d]", i), le[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // d0 counts up throughout; d1 loads 8 and saturates, then loads 1 and floors.
    cycle(3'b000, 3'b010, 3'b101, 3'b111, 0, 8, 0, 1'b1, 1'b1);
    repeat (3) cycle(3'b000, 3'b000, 3'b111, 3'b111, 0, 0, 0, 1'b1, 1'b1);
    cycle(3'b000, 3'b010, 3'b101, 3'b101, 0, 1, 0, 1'b1, 1'b1);
    repeat (3) cycle(3'b000, 3'b000, 3'b111, 3'b101, 0, 0, 0, 1'b1, 1'b1);
    repeat (6) cycle(3'b000, 3'b000, 3'b101, 3'b101, 0, 0, 0, 1'b1, 1'b1);
    repeat (2) cycle(3'b000, 3'b000, 3'b101, 3'b000, 0, 0, 0, 1'b1, 1'b1);
    // Load range and priority; d2 loads its top value 7 legally.
    cycle(3'b000, 3'b101, 3'b000, 3'b000, 5, 0, 7, 1'b1, 1'b1);
    cycle(3'b000, 3'b001, 3'b000, 3'b000, 7, 0, 0, 1'b1, 1'b1);
    cycle(3'b001, 3'b001, 3'b001, 3'b001, 3, 0, 0, 1'b1, 1'b1);
    cycle(3'b000, 3'b001, 3'b001, 3'b001, 2, 0, 0, 1'b1, 1'b1);
    // Cascade completes 100 up-edges back to 00, then steps down to 99.
    repeat (80) cycle(3'b000, 3'b000, 3'b111, 3'b111, 0, 0, 0, 1'b1, 1'b1);
    cycle(3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 1'b1, 1'b0);
    repeat (300) rnd_cycle();

    // Asynchronous reset between edges with d0 at 4.
    cycle(3'b000, 3'b001, 3'b000, 3'b000, 4, 0, 0, 1'b0, 1'b1);
    drain();
    check("pre_reset_q0", q0, 4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en = 3'b111; up = 3'b111; cas_en = 1'b1;
    #1;
    check("async_reset_q0", q0, 0);
    check("async_reset_q1", q1, 0);
    check("async_reset_cascade", {c1_q, c0_q}, 0);
    @(posedge clk);
    #1;
    check("held_reset_q0", q0, 0);
    check("held_reset_q2", q2, 0);
    @(negedge clk);
    en = '0; cas_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) mq[i] = 0;
    cv = 0;
    cycle(3'b000, 3'b000, 3'b111, 3'b111, 0, 0, 0, 1'b1, 1'b1);
    repeat (100) rnd_cycle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_mod_updn.md
# counter_mod_updn

Parametrised synchronous modulo-MOD up/down counter with synchronous clear, parallel load, count enable, and cascade support. It generalises the team's fixed modulo-7 up/down counter to any modulus and width. It adds a selectable wrap or saturate mode and registered wrap/error flags. It is used as a building block for timers, digit counters and multi-stage cascaded counters in the digital system design labs.

## Interface
- MOD, 7, count modulus; legal count values are 0 .. MOD-1; MOD ≥ 2
- WIDTH, 3, counter width in bits; MOD ≤ 2^WIDTH is required, otherwise elaboration fails
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value to load
- en  input  1  count enable; also the cascade carry-in
- up  input  1  direction: 1 = increment, 0 = decrement
- q  output  WIDTH  current count
- tc  output  1  terminal count, combinational; cascade carry-out
- wrap  output  1  registered one-cycle pulse: the previous edge wrapped
- load_err  output  1  registered one-cycle pulse: the previous load was out of range

## Operation
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n = 0 immediately forces q = 0, wrap = 0, load_err = 0, independent of clk.
- Per-edge priority, highest first: clr > load > en > hold.
- clr = 1: q ← 0; wrap ← 0; load_err ← 0.
- load = 1 (clr = 0):
  - If load_val < MOD: q ← load_val and load_err ← 0.
  - Otherwise: q ← MOD-1 and load_err ← 1.
  - wrap ← 0 in both cases.
- en = 1, up = 1 (no clr/load):
  - If q < MOD-1: q ← q+1.
  - If q = MOD-1: with SATURATE = 0, q ← 0 and wrap ← 1; with SATURATE = 1, q holds and wrap ← 0.
- en = 1, up = 0 (no clr/load):
  - If q > 0: q ← q-1.
  - If q = 0: with SATURATE = 0, q ← MOD-1 and wrap ← 1; with SATURATE = 1, q holds and wrap ← 0.
- en = 0 (no clr/load): q holds; wrap ← 0; load_err ← 0.
- tc = en & ((up & q == MOD-1) | (~up & q == 0)). It is asserted in both modes.
- Cascading: connect stage k's tc to stage k+1's en, with the same up to all stages. This forms a base-MOD multi-digit counter with no extra logic.
- Arithmetic: all compares are unsigned at WIDTH bits. q never leaves 0 .. MOD-1, including when MOD = 2^WIDTH, where no out-of-range load is possible.

## Timing
- Latency: q reflects clr, load or count on the first rising edge after the input is sampled high. There are no pipeline stages.
- wrap and load_err rise on the same edge that updates q. They stay high for exactly one cycle unless the condition repeats on consecutive edges.
  - Example: MOD = 2 with continuous counting gives wrap high every other cycle.
- tc is combinational from q, en and up, with no added latency. Downstream stages sample it on the same edge.
- Reset deassertion is asynchronous to clk. The first count occurs on the first rising edge with rst_n = 1.
- Reset asserted mid-count clears q within the same cycle. Any count in progress is discarded, not completed.
- Simultaneous clr and load: clr wins and load_err stays 0.
- Simultaneous load and en: load wins and no count occurs.
- A change of up while en = 1 takes effect on the next edge. There is no extra cycle penalty.

## Test plan
- Reset and up-count, MOD = 7, SATURATE = 0:
  - Stimulus: release rst_n, then en = 1, up = 1 for 8 edges.
  - Required: q = 1,2,3,4,5,6,0,1. wrap is high only in the cycle q = 0. tc is high while q = 6.
- Down-count wrap, MOD = 7:
  - Stimulus: from q = 0, en = 1, up = 0 for 2 edges.
  - Required: q = 6 then 5. wrap pulses once. tc is high while q = 0.
- Saturate mode, MOD = 10, WIDTH = 4, SATURATE = 1:
  - Stimulus: load 8, count up 3 edges.
  - Required: q = 9,9,9 and wrap stays 0.
  - Stimulus: then count down from load 1 for 3 edges.
  - Required: q = 0,0,0.
- Load range and priority, MOD = 7:
  - load_val = 5 → q = 5, load_err = 0.
  - load_val = 7 → q = 6, load_err pulses 1.
  - clr = load = en = 1 with load_val = 3 → q = 0.
  - load = en = 1, up = 1, load_val = 2 → q = 2, not 3.
- Asynchronous reset mid-count:
  - Stimulus: at q = 4, assert rst_n low between clock edges.
  - Required: q = 0 before the next edge. q stays 0 while rst_n is low, then counts from 0.
- Two-stage cascade, MOD = 10:
  - Stimulus: stage0 tc drives stage1 en, count up 100 edges from 00.
  - Required: digits step 00 … 99 and back to 00. Stage1 increments only on stage0 wrap.
  - Stimulus: down-count from 00.
  - Required: 99 on the first edge.
